button_event_decoder: RTL and testbench
=======================================

# button_event_decoder

Sits directly downstream of the debouncer and consumes its clean, clock-synchronous button level. Classifies each button interaction into one-cycle event pulses: press, release, short press, long press and double click. Board-level control logic consumes these pulses. Timing windows are counted in `clk` cycles and set by parameters.

## Interface

- `LONG_CYCLES`, default 50_000_000: number of consecutive high samples that qualifies a press as long; must be ≥ 2.
- `DCLICK_CYCLES`, default 12_500_000: window of low samples after a release during which a second press counts as a double click; must be ≥ 2.
- `CNT_W`, default 26: counter width; must hold max(`LONG_CYCLES`, `DCLICK_CYCLES`).
- `clk`  input  1  system clock; all logic is on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `btn_in`  input  1  debounced button level; high means pressed; already synchronous to `clk`.
- `held`  output  1  registered copy of `btn_in`.
- `press_pulse`  output  1  one-cycle pulse on every 0→1 transition of `btn_in`.
- `release_pulse`  output  1  one-cycle pulse on every 1→0 transition of `btn_in`.
- `short_press`  output  1  one-cycle pulse: single press shorter than `LONG_CYCLES`, with no second press inside the window.
- `long_press`  output  1  one-cycle pulse once a press has been held for `LONG_CYCLES` samples.
- `double_click`  output  1  one-cycle pulse when a second press starts inside the double-click window.

## Operation

- Edge detect:
  - `btn_q` registers `btn_in`.
  - rise = `btn_in` & ~`btn_q`; fall = ~`btn_in` & `btn_q`.
  - `held` = `btn_q`.
- `press_pulse` and `release_pulse` are generated in every state, independent of the FSM.
- FSM states: IDLE, PRESS1, LONG, WAIT2, PRESS2. `cnt` is `CNT_W` bits wide.
- IDLE:
  - on rise: go to PRESS1, `cnt` ← 1.
- PRESS1:
  - `btn_in`=1 and `cnt`==`LONG_CYCLES`-1: assert `long_press`, go to LONG.
  - `btn_in`=1 otherwise: `cnt`++.
  - on fall: go to WAIT2, `cnt` ← 1.
- LONG:
  - on fall: go to IDLE. No `short_press` is issued.
- WAIT2:
  - on rise: assert `double_click`, go to PRESS2.
  - `btn_in`=0 and `cnt`==`DCLICK_CYCLES`-1: assert `short_press`, go to IDLE.
  - `btn_in`=0 otherwise: `cnt`++.
- PRESS2:
  - on fall: go to IDLE. Long-press detection does not apply to the second press.
- At most one of `short_press`, `long_press`, `double_click` is asserted in any cycle; each interaction produces exactly one of them.
- `cnt` never wraps: each branch exits before `cnt` exceeds its limit.

## Timing

- Reset: while `reset`=0, all outputs and `btn_q` are 0 and the FSM is in IDLE. Outputs clear immediately, without waiting for a clock edge.
- Reset mid-operation:
  - Any state and count in progress are abandoned; no pending event fires after release.
  - If `btn_in` is high at the first edge after release, it is treated as a new rise: `press_pulse` is issued and the FSM enters PRESS1.
- All outputs are registered. A condition sampled at edge k drives its output high for the cycle following edge k, for exactly one cycle.
- Edge timing:
  - Rise sampled at edge k: `press_pulse` is high after edge k.
  - Fall sampled at edge f: `release_pulse` is high after edge f.
- Long press: `btn_in` high at edges k … k+`LONG_CYCLES`-1 gives `long_press` after edge k+`LONG_CYCLES`-1.
- Short press: fall at edge f, then `btn_in` low at edges f … f+`DCLICK_CYCLES`-1, gives `short_press` after edge f+`DCLICK_CYCLES`-1.
- Double click: a rise at edge f+j, with 1 ≤ j ≤ `DCLICK_CYCLES`-1, gives `double_click` and `press_pulse` in the same cycle.
- A rise on the edge after `short_press` is issued is handled as a fresh IDLE rise.

## Test plan

All scenarios use `LONG_CYCLES`=8, `DCLICK_CYCLES`=6; edges are numbered from reset release.

- Reset: hold `reset`=0 with `btn_in` toggling → all outputs stay 0. Release with `btn_in`=1 → `press_pulse` after edge 1 only.
- Short press: `btn_in`=1 at edges 10–12, then 0 → `press_pulse` after 10; `release_pulse` after 13; `short_press` after 18; no other events.
- Long press: `btn_in`=1 at edges 10–20 → `long_press` after 17; `release_pulse` after 21; no `short_press` thereafter.
- Double click: high at 10–11, low at 12–14, high at 15–16, then low → `double_click` and `press_pulse` after 15; `release_pulse` after 12 and 17; no `short_press`; FSM back in IDLE after 17.
- Window expiry: high at 10–11, low at 12–17, high from 18 → `short_press` after 17; `press_pulse` after 18 with no `double_click`; FSM in PRESS1.
- Reset mid-operation: rise at edge 10, assert `reset` at edge 13 with `btn_in` held high, release at edge 16 → outputs 0 during reset; `press_pulse` after edge 17; `long_press` after edge 24, not earlier.

Source files
------------

// File: rtl/button_event_decoder.sv
// Classifies a clean, clock-synchronous button level into one-cycle event pulses:
// press, release, short press, long press and double click.
module button_event_decoder #(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int DCLICK_CYCLES = 12_500_000,
  parameter int CNT_W         = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic held,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic double_click
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS1,
    S_LONG,
    S_WAIT2,
    S_PRESS2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             btn_q;
  logic             rise, fall;
  logic             short_next, long_next, dclick_next;

  assign rise = btn_in & ~btn_q;
  assign fall = ~btn_in & btn_q;
  assign held = btn_q;

  // State register; event outputs are registered alongside so every pulse
  // appears in the cycle after the edge that sampled its condition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      btn_q         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      double_click  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      btn_q         <= btn_in;
      press_pulse   <= rise;
      release_pulse <= fall;
      short_press   <= short_next;
      long_press    <= long_next;
      double_click  <= dclick_next;
    end
  end

  // Each counting branch leaves at its limit, so cnt never wraps.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (rise) begin
          state_next = S_PRESS1;
          cnt_next   = CNT_ONE;
        end
      end
      S_PRESS1: begin
        if (fall) begin
          state_next = S_WAIT2;
          cnt_next   = CNT_ONE;
        end else if (btn_in) begin
          if (cnt_reg == LONG_LAST) begin
            state_next = S_LONG;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
      end
      S_LONG: begin
        if (fall) begin
          state_next = S_IDLE;
        end
      end
      S_WAIT2: begin
        if (rise) begin
          state_next = S_PRESS2;
          cnt_next   = '0;
        end else if (!btn_in) begin
          if (cnt_reg == DCLICK_LAST) begin
            state_next = S_IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
      end
      S_PRESS2: begin
        if (fall) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // A rise inside the window wins over expiry, so the classified events stay exclusive.
  always_comb begin
    short_next  = 1'b0;
    long_next   = 1'b0;
    dclick_next = 1'b0;
    unique case (state_reg)
      S_PRESS1: long_next   = btn_in && (cnt_reg == LONG_LAST);
      S_WAIT2: begin
        dclick_next = rise;
        short_next  = !btn_in && (cnt_reg == DCLICK_LAST);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: directed scenarios plus random press/release
// segments, checked against an edge-timestamp model of the classification rules.
module tb_button_event_decoder;

  localparam int L = 8;
  localparam int D = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_in = 1'b0;
  logic held, press_pulse, release_pulse, short_press, long_press, double_click;

  int total = 0;
  int passed = 0;
  int fails = 0;

  // Model: edge index, previous sample, start of current press, last release,
  // whether the current press is a second click, and a pending short candidate.
  int k;
  logic m_prev;
  int m_start, m_fall;
  bit m_second, m_cand;
  logic e_press, e_release, e_short, e_long, e_dclick;

  button_event_decoder #(
    .LONG_CYCLES  (L),
    .DCLICK_CYCLES(D),
    .CNT_W        (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_in       (btn_in),
    .held         (held),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_click (double_click)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s at edge %0d: observed %b expected %b", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    k        = 0;
    m_prev   = 1'b0;
    m_start  = 0;
    m_fall   = 0;
    m_second = 1'b0;
    m_cand   = 1'b0;
  endtask

  task automatic model_edge(input logic b);
    k++;
    e_press   = b & ~m_prev;
    e_release = ~b & m_prev;
    e_short   = 1'b0;
    e_long    = 1'b0;
    e_dclick  = 1'b0;
    if (e_press) begin
      m_second = m_cand && ((k - m_fall) <= D - 1);
      e_dclick = m_second;
      m_start  = k;
      m_cand   = 1'b0;
    end else if (e_release) begin
      m_cand = !m_second && ((k - m_start) <= L - 1);
      m_fall = k;
    end else if (b) begin
      e_long = !m_second && ((k - m_start) == L - 1);
    end else if (m_cand && ((k - m_fall) == D - 1)) begin
      e_short = 1'b1;
      m_cand  = 1'b0;
    end
    m_prev = b;
  endtask

  task automatic check_zero(input string phase);
    chk({phase, "_held"}, held, 1'b0);
    chk({phase, "_press"}, press_pulse, 1'b0);
    chk({phase, "_release"}, release_pulse, 1'b0);
    chk({phase, "_short"}, short_press, 1'b0);
    chk({phase, "_long"}, long_press, 1'b0);
    chk({phase, "_dclick"}, double_click, 1'b0);
  endtask

  // Called at a falling edge: drive, sample at the next rising edge, check 1 ns later.
  task automatic step(input logic b);
    btn_in = b;
    @(posedge clk);
    model_edge(b);
    #1;
    chk("held", held, b);
    chk("press_pulse", press_pulse, e_press);
    chk("release_pulse", release_pulse, e_release);
    chk("short_press", short_press, e_short);
    chk("long_press", long_press, e_long);
    chk("double_click", double_click, e_dclick);
    $display("edge %0d btn=%b held=%b press=%b rel=%b short=%b long=%b dclick=%b",
             k, b, held, press_pulse, release_pulse, short_press, long_press, double_click);
    @(negedge clk);
  endtask

  task automatic run(input logic b, input int n);
    for (int i = 0; i < n; i++) step(b);
  endtask

  // Asserted at a falling edge; outputs must clear without waiting for a clock.
  task automatic do_reset(input int n, input bit toggle);
    reset = 1'b0;
    #1;
    check_zero("rst_async");
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_zero("rst_hold");
      @(negedge clk);
      if (toggle) btn_in = 1'($urandom_range(0, 1));
    end
    reset = 1'b1;
    model_reset();
    $display("reset released, btn=%b", btn_in);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset(5, 1'b1);
    step(1'b1);
    run(1'b1, 2);
    run(1'b0, 12);
    // Short press
    run(1'b1, 3);
    run(1'b0, 10);
    // Long press
    run(1'b1, 11);
    run(1'b0, 10);
    // Double click
    run(1'b1, 2);
    run(1'b0, 3);
    run(1'b1, 2);
    run(1'b0, 10);
    // Window expiry, then a fresh press
    run(1'b1, 2);
    run(1'b0, 6);
    run(1'b1, 3);
    run(1'b0, 10);
    // Reset mid-press with the button held through release
    run(1'b1, 3);
    btn_in = 1'b1;
    do_reset(3, 1'b0);
    run(1'b1, 10);
    run(1'b0, 10);
    // Random segments around both window boundaries
    for (int s = 0; s < 70; s++) begin
      if ($urandom_range(0, 14) == 0) do_reset($urandom_range(1, 3), 1'b1);
      run(1'(s % 2), $urandom_range(1, 12));
    end
    run(1'b0, 10);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
